// File: rtl/mpc_mul_acc_pipe.sv
// Pipelined multiply-accumulate with configurable operand signedness, round-half-up
// right shift and saturation of both the running sum and the formatted output.
module mpc_mul_acc_pipe #(
    parameter int DIN0_WIDTH  = 21,
    parameter int DIN1_WIDTH  = 6,
    parameter int DIN0_SIGNED = 1,
    parameter int DIN1_SIGNED = 0,
    parameter int DOUT_WIDTH  = 28,
    parameter int ACC_WIDTH   = 35,
    parameter int NUM_STAGE   = 4,
    parameter int SHIFT       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_vld,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  acc_en,
    input  logic                  acc_clr,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_vld,
    output logic                  ovf
);
    localparam int P          = DIN0_WIDTH + DIN1_WIDTH;
    localparam bit RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
    localparam int W          = ((ACC_WIDTH > DOUT_WIDTH) ? ACC_WIDTH : DOUT_WIDTH) + 2;
    localparam int LAST       = NUM_STAGE - 1;

    // Clamp a wide value into the width-bit range of the result signedness.
    function automatic logic signed [W-1:0] sat_f(input logic signed [W-1:0] v,
                                                  input int width, output logic clipped);
        logic signed [W-1:0] hi, lo;
        if (RES_SIGNED) begin
            hi = (W'(1) << (width - 1)) - W'(1);
            lo = -(W'(1) << (width - 1));
        end else begin
            hi = (W'(1) << width) - W'(1);
            lo = '0;
        end
        clipped = (v > hi) || (v < lo);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic logic signed [W-1:0] round_f(input logic signed [W-1:0] v);
        logic signed [W-1:0] half;
        half = W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0);
        return (SHIFT == 0) ? v : ((v + half) >>> SHIFT);
    endfunction

    // Stage 1: operand capture; sideband bits travel alongside through stage LAST
    logic [DIN0_WIDTH-1:0] a_p1_d, a_p1_q;
    logic [DIN1_WIDTH-1:0] b_p1_d, b_p1_q;
    logic [LAST:1]         vld_d, vld_q, en_d, en_q, clr_d, clr_q;

    always_comb begin
        a_p1_d = a_p1_q;
        b_p1_d = b_p1_q;
        vld_d  = vld_q;
        en_d   = en_q;
        clr_d  = clr_q;
        if (ce) begin
            a_p1_d   = din0;
            b_p1_d   = din1;
            vld_d[1] = in_vld;
            en_d[1]  = acc_en;
            clr_d[1] = acc_clr;
            for (int i = 2; i <= LAST; i++) begin
                vld_d[i] = vld_q[i-1];
                en_d[i]  = en_q[i-1];
                clr_d[i] = clr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        a_p1_q <= a_p1_d;
        b_p1_q <= b_p1_d;
        if (reset) begin
            vld_q <= '0;
            en_q  <= '0;
            clr_q <= '0;
        end else begin
            vld_q <= vld_d;
            en_q  <= en_d;
            clr_q <= clr_d;
        end
    end

    // Extending both operands to P+1 bits lets one signed multiply cover every signedness mix.
    logic signed [P:0] a_ext, b_ext;
    logic [P-1:0]      prod_p1, prod_fin;

    always_comb begin
        a_ext   = {{(P + 1 - DIN0_WIDTH){(DIN0_SIGNED != 0) && a_p1_q[DIN0_WIDTH-1]}}, a_p1_q};
        b_ext   = {{(P + 1 - DIN1_WIDTH){(DIN1_SIGNED != 0) && b_p1_q[DIN1_WIDTH-1]}}, b_p1_q};
        prod_p1 = P'(a_ext * b_ext);
    end

    // Stages 2..LAST: product transport
    generate
        if (NUM_STAGE > 2) begin : g_prod
            logic [P-1:0] prod_d [2:LAST];
            logic [P-1:0] prod_q [2:LAST];

            always_comb begin
                prod_d = prod_q;
                if (ce) begin
                    prod_d[2] = prod_p1;
                    for (int i = 3; i <= LAST; i++) prod_d[i] = prod_q[i-1];
                end
            end

            always_ff @(posedge clk) prod_q <= prod_d;

            assign prod_fin = prod_q[LAST];
        end else begin : g_noprod
            assign prod_fin = prod_p1;
        end
    endgenerate

    // Stage NUM_STAGE: accumulate, round, saturate
    logic [ACC_WIDTH-1:0]  acc_d, acc_q;
    logic [DOUT_WIDTH-1:0] dout_d, dout_q;
    logic                  ovf_d, ovf_q, dout_vld_d, dout_vld_q;
    logic signed [W-1:0]   prod_w, acc_w, sum_w, next_w, rnd_w, out_w;
    logic                  acc_sat, out_sat, use_sum;

    always_comb begin
        prod_w  = {{(W - P){RES_SIGNED && prod_fin[P-1]}}, prod_fin};
        acc_w   = {{(W - ACC_WIDTH){RES_SIGNED && acc_q[ACC_WIDTH-1]}}, acc_q};
        sum_w   = sat_f(acc_w + prod_w, ACC_WIDTH, acc_sat);
        use_sum = en_q[LAST] && !clr_q[LAST];
        next_w  = use_sum ? sum_w : prod_w;
        rnd_w   = round_f(next_w);
        out_w   = sat_f(rnd_w, DOUT_WIDTH, out_sat);

        acc_d      = acc_q;
        dout_d     = dout_q;
        ovf_d      = ovf_q;
        dout_vld_d = dout_vld_q;
        if (ce) begin
            dout_vld_d = vld_q[LAST];
            if (vld_q[LAST]) begin
                acc_d  = ACC_WIDTH'(next_w);
                dout_d = DOUT_WIDTH'(out_w);
                ovf_d  = (use_sum && acc_sat) || out_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            dout_q     <= '0;
            ovf_q      <= 1'b0;
            dout_vld_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            dout_q     <= dout_d;
            ovf_q      <= ovf_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign ovf      = ovf_q;
endmodule
